// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite response codes, response type and byte-lane helper
package axil_pkg;
  typedef logic [1:0] axil_resp_t;
  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;
  localparam axil_resp_t RESP_DECERR = 2'b11;
  function automatic int clog2_bytes(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/axil_regfile_slave_if.sv
// axil_regfile_slave_if: AXI-Lite bus (AW/W/B/AR/R channels); master drives addr/data/valids/readies, slave drives the rest
interface axil_regfile_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;
  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_strb_merge.sv
// axil_strb_merge: byte-strobe merge; old_i/new_i/strb_i in, merged_o takes new_i bytes where strb_i is set
module axil_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);
  for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_lane
    assign merged_o[b*8 +: 8] = strb_i[b] ? new_i[b*8 +: 8] : old_i[b*8 +: 8];
  end
endmodule

// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI-Lite register file; clk/resetn, bus (AXI-Lite slave), reg_q (RW contents), ro_in (RO sources), wr_pulse (per-register write strobe)
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           resetn,
  axil_regfile_slave_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int AL = clog2_bytes(DATA_WIDTH);
  localparam int IW = ADDR_WIDTH - AL;
  localparam int SW = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic                  aw_full_q, w_full_q, bvalid_q, rvalid_q;
  logic [IW-1:0]         aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q, rdata_q, old_data, merged, rd_data;
  logic [SW-1:0]         w_strb_q;
  axil_resp_t            bresp_q, rresp_q, wr_resp, rd_resp;
  logic [NUM_REGS-1:0]   wr_sel, rd_sel, wr_pulse_q;
  logic                  commit;
  logic [IW-1:0]         ar_idx;
  logic                  unused_lsbs;
  assign ar_idx        = bus.ARADDR[ADDR_WIDTH-1:AL];
  assign unused_lsbs   = &{1'b0, bus.AWADDR[AL-1:0], bus.ARADDR[AL-1:0]};
  assign bus.AWREADY   = !aw_full_q;
  assign bus.WREADY    = !w_full_q;
  assign bus.ARREADY   = !rvalid_q || bus.RREADY;
  assign bus.BVALID    = bvalid_q;
  assign bus.BRESP     = bresp_q;
  assign bus.RVALID    = rvalid_q;
  assign bus.RDATA     = rdata_q;
  assign bus.RRESP     = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  assign commit        = aw_full_q && w_full_q && (!bvalid_q || bus.BREADY);
  // Decode by equality against each index so no select ever runs past NUM_REGS.
  always_comb begin
    wr_sel   = '0;
    rd_sel   = '0;
    old_data = '0;
    rd_data  = '0;
    reg_q    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = aw_idx_q == IW'(i);
      rd_sel[i] = ar_idx == IW'(i);
      if (wr_sel[i]) old_data = mem_q[i];
      if (rd_sel[i]) rd_data = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : mem_q[i];
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
    end
    wr_resp = !(|wr_sel) ? RESP_DECERR : |(wr_sel & RO_MASK) ? RESP_SLVERR : RESP_OKAY;
    rd_resp = |rd_sel ? RESP_OKAY : RESP_DECERR;
  end
  axil_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_i   (old_data),
    .new_i   (w_data_q),
    .strb_i  (w_strb_q),
    .merged_o(merged)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      mem_q      <= '{default: '0};
    end else begin
      if (bus.AWVALID && !aw_full_q) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= bus.AWADDR[ADDR_WIDTH-1:AL];
      end
      if (bus.WVALID && !w_full_q) begin
        w_full_q <= 1'b1;
        w_data_q <= bus.WDATA;
        w_strb_q <= bus.WSTRB;
      end
      // Both holding slots are full on commit, so no new handshake can race the clear.
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bresp_q   <= wr_resp;
      end
      bvalid_q   <= commit || (bvalid_q && !bus.BREADY);
      wr_pulse_q <= commit ? wr_sel & ~RO_MASK : '0;
      for (int i = 0; i < NUM_REGS; i++)
        if (commit && wr_sel[i] && !RO_MASK[i]) mem_q[i] <= merged;
      if (bus.ARVALID && bus.ARREADY) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
      if (bus.ARREADY) rvalid_q <= bus.ARVALID;
    end
  end
endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: directed table-driven bench plus hand sequences for ordering, backpressure, collision and reset
module tb_axil_regfile_slave;
  import axil_pkg::*;
  localparam int AW = 8, DW = 32, NR = 16;
  localparam logic [NR-1:0] ROM = 16'h0008;
  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [15:0] pulse;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NR*DW-1:0] reg_q, ro_in;
  logic [NR-1:0] wr_pulse;
  int errors = 0, checks = 0;
  vec_t vt [15];
  axil_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  axil_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(ROM)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus.slave),
    .reg_q   (reg_q),
    .ro_in   (ro_in),
    .wr_pulse(wr_pulse)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rq(input int idx);
    return reg_q[idx*DW +: DW];
  endfunction
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [15:0] pulse, output bit ok);
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 0; w_done = 0; ok = 0; resp = 2'b00; pulse = '0;
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s; bus.AWVALID = 1; bus.WVALID = 1;
    for (int n = 0; n < 10 && !(aw_done && w_done); n++) begin
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      step();
      if (aw_hs) begin aw_done = 1; bus.AWVALID = 0; end
      if (w_hs) begin w_done = 1; bus.WVALID = 0; end
    end
    bus.AWVALID = 0; bus.WVALID = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.BVALID) begin ok = 1; resp = bus.BRESP; pulse = wr_pulse; break; end
      step();
    end
    step();
  endtask
  task automatic axi_read(input logic [7:0] a, output logic [31:0] data, output logic [1:0] resp, output bit ok);
    bit hs;
    ok = 0; data = '0; resp = 2'b00;
    bus.ARADDR = a; bus.ARVALID = 1;
    for (int n = 0; n < 10; n++) begin
      hs = bus.ARREADY;
      step();
      if (hs) break;
    end
    bus.ARVALID = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.RVALID) begin ok = 1; data = bus.RDATA; resp = bus.RRESP; break; end
      step();
    end
    step();
  endtask
  initial begin
    logic [1:0] r;
    logic [15:0] p;
    logic [31:0] d;
    bit ok;
    bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
    bus.BREADY = 1; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 1;
    ro_in = '0;
    ro_in[3*DW +: DW] = 32'hCAFEF00D;
    ro_in[1*DW +: DW] = 32'hBAD0BAD0;
    vt[0]  = '{1, 8'h04, 32'hDEADBEEF, 4'hF, RESP_OKAY,   16'h0002, 32'hDEADBEEF};
    vt[1]  = '{0, 8'h04, 32'h0,        4'h0, RESP_OKAY,   16'h0000, 32'hDEADBEEF};
    vt[2]  = '{1, 8'h08, 32'hAABBCCDD, 4'hF, RESP_OKAY,   16'h0004, 32'hAABBCCDD};
    vt[3]  = '{0, 8'h08, 32'h0,        4'h0, RESP_OKAY,   16'h0000, 32'hAABBCCDD};
    vt[4]  = '{1, 8'h0C, 32'h12345678, 4'hF, RESP_SLVERR, 16'h0000, 32'h00000000};
    vt[5]  = '{0, 8'h0C, 32'h0,        4'h0, RESP_OKAY,   16'h0000, 32'hCAFEF00D};
    vt[6]  = '{1, 8'h40, 32'h11111111, 4'hF, RESP_DECERR, 16'h0000, 32'h00000000};
    vt[7]  = '{0, 8'h40, 32'h0,        4'h0, RESP_DECERR, 16'h0000, 32'h00000000};
    vt[8]  = '{1, 8'h3C, 32'h55667788, 4'hC, RESP_OKAY,   16'h8000, 32'h55660000};
    vt[9]  = '{0, 8'h3C, 32'h0,        4'h0, RESP_OKAY,   16'h0000, 32'h55660000};
    vt[10] = '{1, 8'h04, 32'h00000000, 4'h0, RESP_OKAY,   16'h0002, 32'hDEADBEEF};
    vt[11] = '{0, 8'h05, 32'h0,        4'h0, RESP_OKAY,   16'h0000, 32'hDEADBEEF};
    vt[12] = '{0, 8'h00, 32'h0,        4'h0, RESP_OKAY,   16'h0000, 32'h00000000};
    vt[13] = '{0, 8'h3F, 32'h0,        4'h0, RESP_OKAY,   16'h0000, 32'h55660000};
    vt[14] = '{0, 8'h44, 32'h0,        4'h0, RESP_DECERR, 16'h0000, 32'h00000000};
    step();
    step();
    check("rst awready", bus.AWREADY, 1);
    check("rst wready", bus.WREADY, 1);
    check("rst arready", bus.ARREADY, 1);
    check("rst bvalid", bus.BVALID, 0);
    check("rst rvalid", bus.RVALID, 0);
    check("rst wr_pulse", wr_pulse, 0);
    check("rst regs", |reg_q, 0);
    check("rst rdata", bus.RDATA, 0);
    resetn = 1;
    step();
    for (int i = 0; i < 15; i++) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, r, p, ok);
        check($sformatf("v%0d bvalid seen", i), ok, 1);
        check($sformatf("v%0d bresp", i), r, vt[i].resp);
        check($sformatf("v%0d wr_pulse", i), p, vt[i].pulse);
        check($sformatf("v%0d pulse width", i), wr_pulse, 0);
        if (vt[i].resp != RESP_DECERR) check($sformatf("v%0d reg", i), rq(int'(vt[i].addr[7:2])), vt[i].exp);
      end else begin
        axi_read(vt[i].addr, d, r, ok);
        check($sformatf("v%0d rvalid seen", i), ok, 1);
        check($sformatf("v%0d rresp", i), r, vt[i].resp);
        check($sformatf("v%0d rdata", i), d, vt[i].exp);
      end
    end
    bus.WDATA = 32'h11223344; bus.WSTRB = 4'b0101; bus.WVALID = 1;
    step();
    bus.WVALID = 0;
    check("wfirst wready low", bus.WREADY, 0);
    check("wfirst awready high", bus.AWREADY, 1);
    step();
    step();
    check("wfirst no bvalid", bus.BVALID, 0);
    bus.AWADDR = 8'h08; bus.AWVALID = 1;
    step();
    bus.AWVALID = 0;
    check("wfirst bvalid latency", bus.BVALID, 0);
    step();
    check("wfirst bvalid", bus.BVALID, 1);
    check("wfirst bresp", bus.BRESP, RESP_OKAY);
    check("wfirst pulse", wr_pulse, 16'h0004);
    step();
    check("wfirst merged", rq(2), 32'hAA22CC44);
    check("wfirst bvalid clear", bus.BVALID, 0);
    bus.BREADY = 0;
    bus.AWADDR = 8'h10; bus.WDATA = 32'h1; bus.WSTRB = 4'hF; bus.AWVALID = 1; bus.WVALID = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    step();
    check("bp first bvalid", bus.BVALID, 1);
    check("bp first pulse", wr_pulse, 16'h0010);
    bus.AWADDR = 8'h14; bus.WDATA = 32'h2; bus.AWVALID = 1; bus.WVALID = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    repeat (3) step();
    check("bp hold bvalid", bus.BVALID, 1);
    check("bp hold bresp", bus.BRESP, RESP_OKAY);
    check("bp hold no pulse", wr_pulse, 0);
    check("bp awready full", bus.AWREADY, 0);
    check("bp wready full", bus.WREADY, 0);
    check("bp second pending", rq(5), 0);
    bus.BREADY = 1;
    step();
    check("bp second bvalid", bus.BVALID, 1);
    check("bp second pulse", wr_pulse, 16'h0020);
    check("bp second reg", rq(5), 32'h2);
    step();
    check("bp bvalid clear", bus.BVALID, 0);
    bus.RREADY = 0; bus.ARADDR = 8'h04; bus.ARVALID = 1;
    step();
    bus.ARADDR = 8'h08;
    check("rstall rvalid", bus.RVALID, 1);
    check("rstall arready", bus.ARREADY, 0);
    repeat (3) step();
    check("rstall rvalid held", bus.RVALID, 1);
    check("rstall rdata held", bus.RDATA, 32'hDEADBEEF);
    check("rstall arready held", bus.ARREADY, 0);
    bus.RREADY = 1;
    step();
    bus.ARVALID = 0;
    check("rstall next rvalid", bus.RVALID, 1);
    check("rstall next rdata", bus.RDATA, 32'hAA22CC44);
    step();
    check("rstall rvalid clear", bus.RVALID, 0);
    bus.ARADDR = 8'h00; bus.ARVALID = 1;
    step();
    check("b2b r0 valid", bus.RVALID, 1);
    check("b2b r0 data", bus.RDATA, 0);
    bus.ARADDR = 8'h04;
    step();
    check("b2b r1 valid", bus.RVALID, 1);
    check("b2b r1 data", bus.RDATA, 32'hDEADBEEF);
    bus.ARADDR = 8'h08;
    step();
    bus.ARVALID = 0;
    check("b2b r2 valid", bus.RVALID, 1);
    check("b2b r2 data", bus.RDATA, 32'hAA22CC44);
    step();
    check("b2b end", bus.RVALID, 0);
    bus.AWADDR = 8'h04; bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF; bus.AWVALID = 1; bus.WVALID = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    bus.ARADDR = 8'h04; bus.ARVALID = 1;
    step();
    bus.ARVALID = 0;
    check("coll bvalid", bus.BVALID, 1);
    check("coll old data", bus.RDATA, 32'hDEADBEEF);
    step();
    axi_read(8'h04, d, r, ok);
    check("coll new data", d, 32'h0BADF00D);
    bus.BREADY = 0; bus.RREADY = 0;
    bus.AWADDR = 8'h08; bus.WDATA = 32'h77; bus.AWVALID = 1; bus.WVALID = 1;
    bus.ARADDR = 8'h08; bus.ARVALID = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
    step();
    check("mid bvalid", bus.BVALID, 1);
    check("mid rvalid", bus.RVALID, 1);
    check("mid pulse", wr_pulse, 16'h0004);
    #2;
    resetn = 0;
    #1;
    check("arst bvalid", bus.BVALID, 0);
    check("arst rvalid", bus.RVALID, 0);
    check("arst pulse", wr_pulse, 0);
    check("arst awready", bus.AWREADY, 1);
    check("arst wready", bus.WREADY, 1);
    check("arst arready", bus.ARREADY, 1);
    step();
    resetn = 1; bus.BREADY = 1; bus.RREADY = 1;
    step();
    check("arst regs", |reg_q, 0);
    axi_read(8'h04, d, r, ok);
    check("arst read r1", d, 0);
    axi_read(8'h08, d, r, ok);
    check("arst read r2", d, 0);
    check("arst no stray b", bus.BVALID, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
